// File: rtl/word_serializer.sv
// Parallel-to-serial word shifter with a one-word pending buffer.
// Streams back-to-back words with no idle gap between them.
`timescale 1ns/1ps
module word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;

    logic             accept;
    logic             last_bit;
    logic             cur_bit;
    logic [WIDTH-1:0] shifted;

    assign in_ready  = !pend_v_q && !rst;
    assign accept    = in_valid && in_ready;
    assign ser_valid = (state_q == S_SHIFT);
    assign busy      = (state_q == S_SHIFT) || pend_v_q;
    assign last_bit  = (state_q == S_SHIFT) && bit_en && (cnt_q == LAST);
    assign word_done = last_bit;
    assign cur_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign ser_bit   = ser_valid ? cur_bit : IDLE_BIT;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (pend_v_q) begin
                        shift_d  = pend_q;
                        pend_v_d = 1'b0;
                    end else if (accept) begin
                        shift_d = in_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (bit_en) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 1'b1;
                    end
                    // word arriving mid-shift parks in the pending slot
                    if (accept) begin
                        pend_d   = in_data;
                        pend_v_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: MSB-first and LSB-first instances on shared
// stimulus, scoreboard queues of expected bits, vector table plus corner sequences.
`timescale 1ns/1ps
module tb_word_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       bit_en = 1'b1;
    int         en_mode = 0;

    logic [7:0] exp_m = 8'h00;
    logic [7:0] exp_l = 8'h00;

    logic rdy_m, bit_m, val_m, done_m, busy_m;
    logic rdy_l, bit_l, val_l, done_l, busy_l;

    int checks = 0;
    int errors = 0;

    bit q_m[$];
    bit q_l[$];
    int pos_m = 0;
    int pos_l = 0;

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .bit_en(bit_en), .ser_bit(bit_m),
        .ser_valid(val_m), .word_done(done_m), .busy(busy_m)
    );

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .bit_en(bit_en), .ser_bit(bit_l),
        .ser_valid(val_l), .word_done(done_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (en_mode)
            0: bit_en = 1'b1;
            1: bit_en = ~bit_en;
            default: bit_en = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin : monitor
        bit ev_m;
        bit ev_l;
        if (rst) begin
            q_m.delete();
            q_l.delete();
            pos_m = 0;
            pos_l = 0;
        end else begin
            ev_m = (q_m.size() != 0);
            ev_l = (q_l.size() != 0);
            chk("valid_m", val_m, ev_m);
            chk("valid_l", val_l, ev_l);
            chk("busy_m", busy_m, ev_m);
            chk("done_m", done_m, ev_m && bit_en && pos_m == 7);
            chk("done_l", done_l, ev_l && bit_en && pos_l == 7);
            if (!ev_m) chk("idle_bit_m", bit_m, 1);
            if (!ev_l) chk("idle_bit_l", bit_l, 1);
            if (ev_m && bit_en) begin
                chk("bit_m", bit_m, q_m.pop_front());
                pos_m = (pos_m == 7) ? 0 : pos_m + 1;
            end
            if (ev_l && bit_en) begin
                chk("bit_l", bit_l, q_l.pop_front());
                pos_l = (pos_l == 7) ? 0 : pos_l + 1;
            end
            if (in_valid && rdy_m)
                for (int i = 7; i >= 0; i--) q_m.push_back(exp_m[i]);
            if (in_valid && rdy_l)
                for (int i = 7; i >= 0; i--) q_l.push_back(exp_l[i]);
        end
    end

    // em/el list the expected serial order, leftmost bit first
    task automatic send(input logic [7:0] d, input logic [7:0] em,
                        input logic [7:0] el);
        bit ok;
        ok = 1'b0;
        in_data  = d;
        exp_m    = em;
        exp_l    = el;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rdy_m) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word %0h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (q_m.size() == 0 && q_l.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout left %0d", q_m.size());
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] em;
        logic [7:0] el;
        int         mode;
        int         gap;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hist;
        int         hits;
        int         hit_at;

        vecs[0] = '{8'h55, 8'b0101_0101, 8'b1010_1010, 0, 12};
        vecs[1] = '{8'hA5, 8'b1010_0101, 8'b1010_0101, 0, 0};
        vecs[2] = '{8'h0F, 8'b0000_1111, 8'b1111_0000, 0, 20};
        vecs[3] = '{8'hF0, 8'b1111_0000, 8'b0000_1111, 1, 30};
        vecs[4] = '{8'h0A, 8'b0000_1010, 8'b0101_0000, 0, 12};
        vecs[5] = '{8'h3C, 8'b0011_1100, 8'b0011_1100, 2, 0};
        vecs[6] = '{8'hC6, 8'b1100_0110, 8'b0110_0011, 2, 0};
        vecs[7] = '{8'h81, 8'b1000_0001, 8'b1000_0001, 2, 40};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", rdy_m, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", rdy_m, 1);
        chk("post_rst_valid", val_m, 0);
        chk("post_rst_bit", bit_m, 1);
        chk("post_rst_busy", busy_m, 0);
        chk("post_rst_done", done_m, 0);
        @(posedge clk);
        #1;

        // vector table
        foreach (vecs[k]) begin
            en_mode = vecs[k].mode;
            send(vecs[k].data, vecs[k].em, vecs[k].el);
            repeat (vecs[k].gap) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();

        // back-to-back: pending slot holds in_ready low until reload
        en_mode = 0;
        send(8'hA5, 8'b1010_0101, 8'b1010_0101);
        send(8'h0F, 8'b0000_1111, 8'b1111_0000);
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_c%0d", c), rdy_m, (c == 9));
            @(posedge clk);
            #1;
        end
        wait_idle();

        // reset mid-word with a pending word
        send(8'hFF, 8'hFF, 8'hFF);
        send(8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", rdy_m, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", val_m, 0);
        chk("midrst_busy", busy_m, 0);
        chk("midrst_ready1", rdy_m, 1);
        chk("midrst_done", done_m, 0);
        @(posedge clk);
        #1;
        send(8'h81, 8'b1000_0001, 8'b1000_0001);
        wait_idle();

        // 0101 overlapping detector fed from the MSB-first stream
        hist   = 4'b1111;
        hits   = 0;
        hit_at = -1;
        send(8'h50, 8'b0101_0000, 8'b0000_1010);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ({hist[2:0], bit_m} == 4'b0101) begin
                hits++;
                if (hit_at < 0) hit_at = c;
            end
            hist = {hist[2:0], bit_m};
            @(posedge clk);
            #1;
        end
        chk("det_hits", hits, 1);
        chk("det_cycle", hit_at, 4);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
